// File: rtl/alu_mc.sv
// Multi-cycle integer ALU: single-cycle logic/arith/shift/compare ops plus
// iterative shift-add multiply and restoring unsigned divide/remainder.
module alu_mc #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_SLT  = 4'd4;
    localparam logic [3:0] OP_SLTU = 4'd5;
    localparam logic [3:0] OP_SLL  = 4'd6;
    localparam logic [3:0] OP_SRL  = 4'd7;
    localparam logic [3:0] OP_SRA  = 4'd8;
    localparam logic [3:0] OP_MUL  = 4'd9;
    localparam logic [3:0] OP_DIVU = 4'd10;
    localparam logic [3:0] OP_REMU = 4'd11;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    logic [SHW:0]     cnt;
    logic [3:0]       op_q;
    // acc: product accumulator (MUL) or partial remainder (DIV/REM)
    // opa: shifting multiplicand (MUL) or dividend shifting into quotient
    logic [WIDTH-1:0] acc, opa, opb;

    logic [WIDTH-1:0] quick_res;
    logic [WIDTH-1:0] acc_n, opa_n, opb_n, iter_res;
    logic [WIDTH:0]   shifted, diff;
    logic [SHW-1:0]   sh;

    assign sh = b[SHW-1:0];

    always_comb begin
        quick_res = '0;
        case (alu_op)
            OP_ADD:  quick_res = a + b;
            OP_SUB:  quick_res = a - b;
            OP_AND:  quick_res = a & b;
            OP_OR:   quick_res = a | b;
            OP_SLT:  quick_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU: quick_res = {{(WIDTH-1){1'b0}}, a < b};
            OP_SLL:  quick_res = a << sh;
            OP_SRL:  quick_res = a >> sh;
            OP_SRA:  quick_res = $signed(a) >>> sh;
            default: quick_res = '0;
        endcase
    end

    // One iteration step; the last step feeds the result register directly.
    always_comb begin
        acc_n    = acc;
        opa_n    = opa;
        opb_n    = opb;
        shifted  = {acc, opa[WIDTH-1]};
        diff     = shifted - {1'b0, opb};
        if (op_q == OP_MUL) begin
            acc_n = acc + (opb[0] ? opa : '0);
            opa_n = opa << 1;
            opb_n = opb >> 1;
        end else if (!diff[WIDTH]) begin
            acc_n = diff[WIDTH-1:0];
            opa_n = {opa[WIDTH-2:0], 1'b1};
        end else begin
            acc_n = shifted[WIDTH-1:0];
            opa_n = {opa[WIDTH-2:0], 1'b0};
        end
        iter_res = (op_q == OP_DIVU) ? opa_n : acc_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            op_q      <= '0;
            acc       <= '0;
            opa       <= '0;
            opb       <= '0;
            result    <= '0;
            zero      <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    op_q     <= alu_op;
                    in_ready <= 1'b0;
                    if (alu_op == OP_MUL || alu_op == OP_DIVU || alu_op == OP_REMU) begin
                        state <= BUSY;
                        cnt   <= (SHW+1)'(WIDTH);
                        acc   <= '0;
                        opa   <= a;
                        opb   <= b;
                    end else begin
                        state     <= DONE;
                        result    <= quick_res;
                        zero      <= (quick_res == '0);
                        out_valid <= 1'b1;
                    end
                end
                BUSY: begin
                    cnt <= cnt - 1'b1;
                    acc <= acc_n;
                    opa <= opa_n;
                    opb <= opb_n;
                    if (cnt == (SHW+1)'(1)) begin
                        state     <= DONE;
                        result    <= iter_res;
                        zero      <= (iter_res == '0);
                        out_valid <= 1'b1;
                    end
                end
                DONE: if (out_ready) begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc: 32-bit directed vectors plus an 8-bit instance
// checked against a behavioural reference.
module tb_alu_mc;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, zero;
    logic [31:0] a, b, result;
    logic [3:0]  alu_op;

    logic       in_valid8, in_ready8, out_valid8, out_ready8, zero8;
    logic [7:0] a8, b8, result8;
    logic [3:0] alu_op8;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .alu_op(alu_op), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .zero(zero)
    );

    alu_mc #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .alu_op(alu_op8), .out_valid(out_valid8),
        .out_ready(out_ready8), .result(result8), .zero(zero8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] ref8(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y);
        case (op)
            4'd0:  return x + y;
            4'd1:  return x - y;
            4'd2:  return x & y;
            4'd3:  return x | y;
            4'd4:  return ($signed(x) < $signed(y)) ? 8'd1 : 8'd0;
            4'd5:  return (x < y) ? 8'd1 : 8'd0;
            4'd6:  return x << y[2:0];
            4'd7:  return x >> y[2:0];
            4'd8:  return $signed(x) >>> y[2:0];
            4'd9:  return 8'((16'(x) * 16'(y)));
            4'd10: return (y == 0) ? 8'hFF : x / y;
            4'd11: return (y == 0) ? x : x % y;
            default: return 8'd0;
        endcase
    endfunction

    // Accept one op on the 32-bit DUT, scramble inputs, wait for the result,
    // check value/zero/latency, then complete the output handshake.
    task automatic run32(input string tag, input logic [3:0] op, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] exp, input int exp_lat,
                         input bit poke);
        int lat;
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1; alu_op = op; a = x; b = y;
        tick();
        in_valid = 1'b0; a = $urandom; b = $urandom; alu_op = 4'd0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            if (poke) in_valid = (lat >= 2 && lat <= 4);
            tick();
            lat++;
        end
        in_valid = 1'b0;
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_res"}, result, exp);
        chk({tag, "_zero"}, 32'(zero), 32'(exp == 0));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_release"}, {30'd0, in_ready, out_valid}, 32'b10);
    endtask

    task automatic run8(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y);
        int lat;
        logic [7:0] exp;
        exp = ref8(op, x, y);
        in_valid8 = 1'b1; alu_op8 = op; a8 = x; b8 = y;
        tick();
        in_valid8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); alu_op8 = 4'($urandom);
        lat = 1;
        while (!out_valid8 && lat < 50) begin
            tick();
            lat++;
        end
        chk($sformatf("w8_op%0d_lat", op), 32'(lat), (op >= 9 && op <= 11) ? 32'd9 : 32'd1);
        chk($sformatf("w8_op%0d_%h_%h", op, x, y), 32'(result8), 32'(exp));
        chk($sformatf("w8_op%0d_zero", op), 32'(zero8), 32'(exp == 0));
        out_ready8 = 1'b1;
        tick();
        out_ready8 = 1'b0;
    endtask

    initial begin
        logic [31:0] hold;
        bit stale;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; alu_op = '0;
        in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0; alu_op8 = '0;
        tick(); tick();
        chk("rst_state", {28'd0, in_ready, out_valid, zero, 1'b0}, 32'b1000);
        chk("rst_result", result, 32'd0);
        chk("rst_state8", {29'd0, in_ready8, out_valid8, zero8}, 32'b100);
        rst = 1'b0;
        tick();

        // reset in the middle of a multiply
        in_valid = 1'b1; alu_op = 4'd9; a = 32'd7; b = 32'd6;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_state", {29'd0, in_ready, out_valid, zero}, 32'b100);
        chk("midrst_result", result, 32'd0);
        stale = 1'b0;
        repeat (40) begin
            tick();
            if (out_valid) stale = 1'b1;
        end
        chk("midrst_stale", 32'(stale), 32'd0);

        run32("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1, 1'b0);
        run32("sub",      4'd1, 32'd5, 32'd7, 32'hFFFF_FFFE, 1, 1'b0);
        run32("slt",      4'd4, 32'h8000_0000, 32'd1, 32'd1, 1, 1'b0);
        run32("sltu",     4'd5, 32'h8000_0000, 32'd1, 32'd0, 1, 1'b0);
        run32("sra",      4'd8, 32'h8000_0000, 32'h21, 32'hC000_0000, 1, 1'b0);
        run32("sll",      4'd6, 32'h0000_0003, 32'h1F, 32'h8000_0000, 1, 1'b0);
        run32("op13",     4'd13, 32'h1234, 32'h5678, 32'd0, 1, 1'b0);
        run32("mul",      4'd9, 32'h0001_0000, 32'h0001_0001, 32'h0001_0000, 33, 1'b1);
        run32("divu",     4'd10, 32'd100, 32'd7, 32'd14, 33, 1'b0);
        run32("remu",     4'd11, 32'd100, 32'd7, 32'd2, 33, 1'b0);
        run32("divu0",    4'd10, 32'd5, 32'd0, 32'hFFFF_FFFF, 33, 1'b0);
        run32("remu0",    4'd11, 32'd5, 32'd0, 32'd5, 33, 1'b0);

        // backpressure: result held while out_ready stays low
        in_valid = 1'b1; alu_op = 4'd3; a = 32'hA0; b = 32'h0B;
        tick();
        in_valid = 1'b1; alu_op = 4'd0; a = 32'd1; b = 32'd1;
        hold = result;
        stale = 1'b0;
        repeat (10) begin
            tick();
            if (result !== hold || in_ready !== 1'b0 || out_valid !== 1'b1) stale = 1'b1;
        end
        in_valid = 1'b0;
        chk("bp_first", hold, 32'hAB);
        chk("bp_stable", 32'(stale), 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_idle", {30'd0, in_ready, out_valid}, 32'b10);
        in_valid = 1'b1; alu_op = 4'd2; a = 32'hF0F0; b = 32'hFF00;
        tick();
        in_valid = 1'b0;
        chk("bp_next_valid", 32'(out_valid), 32'd1);
        chk("bp_next_res", result, 32'hF000);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // 8-bit instance: fixed corner cases then random ops
        run8(4'd9,  8'hFF, 8'hFF);
        run8(4'd10, 8'hC8, 8'h00);
        run8(4'd11, 8'hC8, 8'h00);
        run8(4'd8,  8'h90, 8'hFB);
        run8(4'd15, 8'h12, 8'h34);
        for (int i = 0; i < 40; i++)
            run8(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
